hdmi_frame_gate: RTL and testbench

// Upstream neighbour of hdmi_to_blocks. Takes the raw HDMI YCbCr stream (N pixels/beat),

---
 rtl/hdmi_frame_gate_if.sv | 43 ++++
 rtl/hdmi_frame_gate.sv | 133 +++++++++++++
 tb/tb_hdmi_frame_gate.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_frame_gate_if.sv
// Raw HDMI YCbCr stream in, gated stream with frame markers and error pulses out.
// The source drives through master; hdmi_frame_gate connects through slave.
interface hdmi_frame_gate_if #(
    parameter int N = 2
);
    logic                    en;
    logic                    hdmi_v_sync;
    logic                    hdmi_h_sync;
    logic                    hdmi_data_valid;
    logic signed [N-1:0][7:0] hdmi_data_y;
    logic signed [N-1:0][7:0] hdmi_data_cr;
    logic signed [N-1:0][7:0] hdmi_data_cb;

    logic                    out_v_sync;
    logic                    out_h_sync;
    logic                    out_data_valid;
    logic signed [N-1:0][7:0] out_data_y;
    logic signed [N-1:0][7:0] out_data_cr;
    logic signed [N-1:0][7:0] out_data_cb;
    logic                    out_sof;
    logic                    out_sol;
    logic                    out_eol;
    logic                    out_eof;
    logic                    out_abort;
    logic                    err_x;
    logic                    err_y;

    modport master (
        output en, hdmi_v_sync, hdmi_h_sync, hdmi_data_valid,
               hdmi_data_y, hdmi_data_cr, hdmi_data_cb,
        input  out_v_sync, out_h_sync, out_data_valid,
               out_data_y, out_data_cr, out_data_cb,
               out_sof, out_sol, out_eol, out_eof, out_abort, err_x, err_y
    );

    modport slave (
        input  en, hdmi_v_sync, hdmi_h_sync, hdmi_data_valid,
               hdmi_data_y, hdmi_data_cr, hdmi_data_cb,
        output out_v_sync, out_h_sync, out_data_valid,
               out_data_y, out_data_cr, out_data_cb,
               out_sof, out_sol, out_eol, out_eof, out_abort, err_x, err_y
    );
endinterface

// File: rtl/hdmi_frame_gate.sv
// Forwards only beats of correctly started X_RES x Y_RES frames, tags them with
// sof/sol/eol/eof, and pulses err/abort when the raster geometry breaks.
module hdmi_frame_gate #(
    parameter int N     = 2,
    parameter int X_RES = 2160,
    parameter int Y_RES = 1200
) (
    input  logic              clk,
    input  logic              rst,
    hdmi_frame_gate_if.slave  bus
);
    localparam int BPL = X_RES / N;
    localparam int XW  = (BPL > 1)   ? $clog2(BPL)   : 1;
    localparam int YW  = (Y_RES > 1) ? $clog2(Y_RES) : 1;

    typedef enum logic [2:0] {
        WAIT_VS,
        SYNC,
        ARMED,
        ACTIVE,
        DONE,
        DROP
    } state_t;

    state_t          state;
    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;
    logic            err_y_seen;

    logic            in_frame;
    logic            x_last;
    logic            y_last;
    logic            last_beat;
    logic            beat_ok;

    always_comb begin
        in_frame  = (state == ARMED) || (state == ACTIVE);
        x_last    = (x_cnt == XW'(BPL - 1));
        y_last    = (y_cnt == YW'(Y_RES - 1));
        last_beat = in_frame && bus.hdmi_data_valid && x_last && y_last;
        // A beat arriving together with a v_sync rise is only kept when it closes the frame.
        beat_ok   = in_frame && bus.hdmi_data_valid && (!bus.hdmi_v_sync || last_beat);
    end

    // NOTE: every register here is updated with <= so all reads see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= WAIT_VS;
            x_cnt               <= '0;
            y_cnt               <= '0;
            err_y_seen          <= 1'b0;
            bus.out_v_sync      <= 1'b0;
            bus.out_h_sync      <= 1'b0;
            bus.out_data_valid  <= 1'b0;
            bus.out_data_y      <= '0;
            bus.out_data_cr     <= '0;
            bus.out_data_cb     <= '0;
            bus.out_sof         <= 1'b0;
            bus.out_sol         <= 1'b0;
            bus.out_eol         <= 1'b0;
            bus.out_eof         <= 1'b0;
            bus.out_abort       <= 1'b0;
            bus.err_x           <= 1'b0;
            bus.err_y           <= 1'b0;
        end else begin
            bus.out_v_sync      <= bus.hdmi_v_sync;
            bus.out_h_sync      <= bus.hdmi_h_sync;
            bus.out_data_valid  <= beat_ok;
            bus.out_data_y      <= beat_ok ? bus.hdmi_data_y  : '0;
            bus.out_data_cr     <= beat_ok ? bus.hdmi_data_cr : '0;
            bus.out_data_cb     <= beat_ok ? bus.hdmi_data_cb : '0;
            bus.out_sof         <= beat_ok && (x_cnt == '0) && (y_cnt == '0);
            bus.out_sol         <= beat_ok && (x_cnt == '0);
            bus.out_eol         <= beat_ok && x_last;
            bus.out_eof         <= beat_ok && x_last && y_last;
            bus.out_abort       <= 1'b0;
            bus.err_x           <= 1'b0;
            bus.err_y           <= 1'b0;

            case (state)
                WAIT_VS: begin
                    if (bus.hdmi_v_sync) state <= SYNC;
                end

                SYNC: begin
                    x_cnt      <= '0;
                    y_cnt      <= '0;
                    err_y_seen <= 1'b0;
                    if (!bus.hdmi_v_sync) state <= bus.en ? ARMED : DROP;
                end

                ARMED, ACTIVE: begin
                    if (last_beat) begin
                        x_cnt <= '0;
                        y_cnt <= '0;
                        state <= bus.hdmi_v_sync ? SYNC : DONE;
                    end else if (bus.hdmi_v_sync) begin
                        bus.err_y     <= 1'b1;
                        bus.out_abort <= (state == ACTIVE);
                        state         <= SYNC;
                    end else if (bus.hdmi_data_valid) begin
                        state <= ACTIVE;
                        if (x_last) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + YW'(1);
                        end else begin
                            x_cnt <= x_cnt + XW'(1);
                        end
                    end else if (state == ACTIVE && x_cnt != '0) begin
                        // A gap mid-line ends the run; the line is short.
                        bus.err_x     <= 1'b1;
                        bus.out_abort <= 1'b1;
                        state         <= DROP;
                    end
                end

                DONE: begin
                    if (bus.hdmi_data_valid && !err_y_seen) begin
                        bus.err_y  <= 1'b1;
                        err_y_seen <= 1'b1;
                    end
                    if (bus.hdmi_v_sync) state <= SYNC;
                end

                DROP: begin
                    if (bus.hdmi_v_sync) state <= SYNC;
                end

                default: state <= WAIT_VS;
            endcase
        end
    end
endmodule

// File: tb/tb_hdmi_frame_gate.sv
// Scoreboard bench for hdmi_frame_gate with a 16x4 raster (8 beats per line).
// Stimulus queues expected beats; an independent monitor pops and compares them.
module tb_hdmi_frame_gate;
    localparam int N     = 2;
    localparam int X_RES = 16;
    localparam int Y_RES = 4;
    localparam int BPL   = X_RES / N;

    typedef struct packed {
        logic [N-1:0][7:0] y;
        logic [N-1:0][7:0] cr;
        logic [N-1:0][7:0] cb;
        logic              sof;
        logic              sol;
        logic              eol;
        logic              eof;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hdmi_frame_gate_if #(.N(N)) bus ();

    hdmi_frame_gate #(.N(N), .X_RES(X_RES), .Y_RES(Y_RES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    checks        = 0;
    int    failures      = 0;
    int    cyc           = 0;
    int    n_err_x       = 0;
    int    n_err_y       = 0;
    int    n_abort       = 0;
    int    last_beat_cyc = -1;
    int    err_x_cyc     = -1;
    int    abort_cyc     = -1;
    int    base_x        = 0;
    int    base_y        = 0;
    int    base_ab       = 0;
    int    seq           = 0;
    logic  vs_exp        = 1'b0;
    logic  hs_exp        = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: sync delay, marker qualification, beat scoreboard, pulse bookkeeping.
    initial begin : monitor
        beat_t got;
        beat_t want;
        forever begin
            @(negedge clk);
            cyc++;
            check("v_sync_delay", 64'(bus.out_v_sync), 64'(vs_exp));
            check("h_sync_delay", 64'(bus.out_h_sync), 64'(hs_exp));
            vs_exp = rst ? 1'b0 : bus.hdmi_v_sync;
            hs_exp = rst ? 1'b0 : bus.hdmi_h_sync;
            if (bus.out_data_valid) begin
                got = '{y: bus.out_data_y, cr: bus.out_data_cr, cb: bus.out_data_cb,
                        sof: bus.out_sof, sol: bus.out_sol, eol: bus.out_eol, eof: bus.out_eof};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got %0h expected no beat (t=%0t)", got, $time);
                end else begin
                    want = exp_q.pop_front();
                    check("beat", 64'(got), 64'(want));
                end
                last_beat_cyc = cyc;
            end else begin
                check("marker_idle", 64'({bus.out_sof, bus.out_sol, bus.out_eol, bus.out_eof}), 64'(0));
            end
            if (bus.err_x)     begin n_err_x++; err_x_cyc = cyc; end
            if (bus.err_y)     n_err_y++;
            if (bus.out_abort) begin n_abort++; abort_cyc = cyc; end
        end
    end

    function automatic beat_t make_beat(input int k, input int ln, input int b);
        beat_t bt;
        bt.y[0]  = 8'(k);
        bt.y[1]  = 8'(k + 64);
        bt.cr[0] = 8'(100 + k);
        bt.cr[1] = 8'(200 - k);
        bt.cb[0] = 8'(k ^ 'h5a);
        bt.cb[1] = 8'(3 * k);
        bt.sof   = (ln == 0) && (b == 0);
        bt.sol   = (b == 0);
        bt.eol   = (b == BPL - 1);
        bt.eof   = (b == BPL - 1) && (ln == Y_RES - 1);
        return bt;
    endfunction

    task automatic step(input logic vs, input logic hs, input logic dv, input beat_t bt);
        bus.hdmi_v_sync     = vs;
        bus.hdmi_h_sync     = hs;
        bus.hdmi_data_valid = dv;
        bus.hdmi_data_y     = bt.y;
        bus.hdmi_data_cr    = bt.cr;
        bus.hdmi_data_cb    = bt.cb;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic send_line(input int ln, input int nbeats, input bit push, input bit vs_last);
        beat_t bt;
        for (int b = 0; b < nbeats; b++) begin
            seq++;
            bt = make_beat(seq, ln, b);
            if (push) exp_q.push_back(bt);
            step(vs_last && (b == nbeats - 1), 1'b0, 1'b1, bt);
        end
        if (!vs_last) begin
            step(1'b0, 1'b1, 1'b0, '0);
            step(1'b0, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic send_frame(input int lines, input bit push);
        for (int ln = 0; ln < lines; ln++) send_line(ln, BPL, push, 1'b0);
    endtask

    task automatic vsync_pulse(input logic en_val);
        bus.en = en_val;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
        idle(2);
    endtask

    task automatic expect_pulses(input string name, input int ex, input int ey, input int ab);
        idle(3);
        check({name, "_err_x"}, 64'(n_err_x - base_x), 64'(ex));
        check({name, "_err_y"}, 64'(n_err_y - base_y), 64'(ey));
        check({name, "_abort"}, 64'(n_abort - base_ab), 64'(ab));
        base_x  = n_err_x;
        base_y  = n_err_y;
        base_ab = n_abort;
    endtask

    initial begin : stimulus
        beat_t bt;
        bus.en = 1'b0;
        rst    = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);
        check("reset_outputs",
              64'({bus.out_v_sync, bus.out_h_sync, bus.out_data_valid, bus.out_sof, bus.out_sol,
                   bus.out_eol, bus.out_eof, bus.out_abort, bus.err_x, bus.err_y,
                   bus.out_data_y, bus.out_data_cr, bus.out_data_cb}),
              64'(0));
        rst = 1'b0;
        idle(2);

        // 1: clean frame
        vsync_pulse(1'b1);
        send_frame(Y_RES, 1'b1);
        expect_pulses("t1_clean", 0, 0, 0);

        // 2: reset during line 1, rest of frame dropped, next frame clean
        vsync_pulse(1'b1);
        send_line(0, BPL, 1'b1, 1'b0);
        for (int b = 0; b < BPL; b++) begin
            seq++;
            bt = make_beat(seq, 1, b);
            if (b < 3) exp_q.push_back(bt);
            if (b == 3) rst = 1'b1;
            if (b == 5) rst = 1'b0;
            step(1'b0, 1'b0, 1'b1, bt);
        end
        idle(2);
        send_line(2, BPL, 1'b0, 1'b0);
        send_line(3, BPL, 1'b0, 1'b0);
        expect_pulses("t2_reset", 0, 0, 0);
        vsync_pulse(1'b1);
        send_frame(Y_RES, 1'b1);
        expect_pulses("t2_after", 0, 0, 0);

        // 3: short line 1 (5 beats) -> err_x + abort, remainder dropped
        vsync_pulse(1'b1);
        send_line(0, BPL, 1'b1, 1'b0);
        send_line(1, 5, 1'b1, 1'b0);
        send_line(2, BPL, 1'b0, 1'b0);
        send_line(3, BPL, 1'b0, 1'b0);
        check("t3_err_x_timing", 64'(err_x_cyc - last_beat_cyc), 64'(1));
        check("t3_abort_timing", 64'(abort_cyc), 64'(err_x_cyc));
        expect_pulses("t3_short", 1, 0, 1);
        vsync_pulse(1'b1);
        send_frame(Y_RES, 1'b1);
        expect_pulses("t3_after", 0, 0, 0);

        // 4a: fifth line after eof -> dropped, single err_y
        vsync_pulse(1'b1);
        send_frame(Y_RES, 1'b1);
        send_line(4, BPL, 1'b0, 1'b0);
        expect_pulses("t4_extra_line", 0, 1, 0);

        // 4b: three lines then v_sync -> err_y + abort
        vsync_pulse(1'b1);
        send_frame(3, 1'b1);
        vsync_pulse(1'b1);
        expect_pulses("t4_short_frame", 0, 1, 1);
        send_frame(Y_RES, 1'b1);
        expect_pulses("t4_after", 0, 0, 0);

        // 5: en low at frame start drops the frame; mid-frame en toggles are ignored
        vsync_pulse(1'b0);
        send_frame(Y_RES, 1'b0);
        expect_pulses("t5_disabled", 0, 0, 0);
        vsync_pulse(1'b1);
        send_line(0, BPL, 1'b1, 1'b0);
        bus.en = 1'b0;
        send_line(1, BPL, 1'b1, 1'b0);
        bus.en = 1'b1;
        send_line(2, BPL, 1'b1, 1'b0);
        bus.en = 1'b0;
        send_line(3, BPL, 1'b1, 1'b0);
        expect_pulses("t5_en_toggle", 0, 0, 0);

        // 6: last beat coincides with v_sync rise
        vsync_pulse(1'b1);
        send_frame(3, 1'b1);
        send_line(3, BPL, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        idle(2);
        send_frame(Y_RES, 1'b1);
        expect_pulses("t6_coincident", 0, 0, 0);

        idle(5);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
